// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ifu_fetch                                                    |
// | Description : Non-pipelined instruction fetch: one AXI AR/R read per step, |
// |               presents {pc, inst} to execute and waits for its completion. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ifu_fetch #(
    parameter int                   ISA_WIDTH = 64,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(64'h0000_0000_8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ifetch_req,
    input  logic                 ifetch_taken,
    input  logic [ISA_WIDTH-1:0] ifetch_taken_pc,

    output logic                 ifu_vld,
    output logic [ISA_WIDTH-1:0] ifu_pc,
    output logic [ISA_WIDTH-1:0] ifu_inst,
    output logic                 ifu_err,
    output logic [63:0]          inst_cnt,

    output logic [63:0]          axi_AR_ADDR,
    output logic                 axi_AR_VALID,
    input  logic                 axi_AR_READY,
    input  logic [63:0]          axi_R_DATA,
    input  logic                 axi_R_VALID,
    output logic                 axi_R_READY
);

    typedef enum logic [1:0] {
        S_AR   = 2'd0,
        S_R    = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e               state_q;
    logic [ISA_WIDTH-1:0] pc_q;
    logic [ISA_WIDTH-1:0] pc_d;
    logic [ISA_WIDTH-1:0] ifu_pc_q;
    logic [ISA_WIDTH-1:0] ifu_inst_q;
    logic [ISA_WIDTH-1:0] inst_d;
    logic [31:0]          word_d;
    logic                 ifu_vld_q;
    logic                 ifu_err_q;
    logic [63:0]          inst_cnt_q;

    // The 64-bit beat carries two instructions; pc[2] picks the half.
    assign word_d = pc_q[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];
    assign inst_d = ISA_WIDTH'(word_d);
    assign pc_d   = ifetch_taken ? ifetch_taken_pc : pc_q + ISA_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_AR;
            pc_q       <= RESET_PC;
            ifu_pc_q   <= '0;
            ifu_inst_q <= '0;
            ifu_vld_q  <= 1'b0;
            ifu_err_q  <= 1'b0;
            inst_cnt_q <= 64'd0;
        end else begin
            ifu_vld_q <= 1'b0;
            case (state_q)
                S_AR: begin
                    if (axi_AR_READY) begin
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (axi_R_VALID) begin
                        ifu_inst_q <= inst_d;
                        ifu_pc_q   <= pc_q;
                        ifu_vld_q  <= 1'b1;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ifetch_req) begin
                        inst_cnt_q <= inst_cnt_q + 64'd1;
                        // A misaligned target is fatal: keep the old pc and stop fetching.
                        if (pc_d[1:0] != 2'b00) begin
                            ifu_err_q <= 1'b1;
                            state_q   <= S_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= S_AR;
                        end
                    end
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign axi_AR_VALID = (state_q == S_AR) && !rst;
    assign axi_R_READY  = (state_q == S_R) && !rst;
    assign axi_AR_ADDR  = 64'(pc_q);

    assign ifu_vld  = ifu_vld_q;
    assign ifu_pc   = ifu_pc_q;
    assign ifu_inst = ifu_inst_q;
    assign ifu_err  = ifu_err_q;
    assign inst_cnt = inst_cnt_q;

endmodule
`default_nettype wire
